// File: rtl/reg_bank_mp.sv
// reg_bank_mp: multi-ported register file with a per-register pending
// (scoreboard) bit. It has three combinational read ports, two write ports
// (port 1 has priority), and one claim port that marks a register as
// awaiting a result.
module reg_bank_mp #(
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 3,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] rd3,
    output logic          busy1,
    output logic          busy2,
    output logic          busy3,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_a,
    output logic          claim_err
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             claim_err_q;
    logic             claim_err_d;

    // One-hot decode of each write and claim port, with address 0 masked
    // out when it is hard-wired to zero.
    logic [DEPTH-1:0] wr_hit0;
    logic [DEPTH-1:0] wr_hit1;
    logic [DEPTH-1:0] wr_any;
    logic [DEPTH-1:0] clm_hit;

    // Returns 0 for an address that can never be written, claimed or read
    // back as non-zero.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return !((ZERO_R0 != 0) && (a == '0));
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            assign wr_hit0[gi] = we0 && (wa0 == AW'(gi)) && addr_live(wa0);
            assign wr_hit1[gi] = we1 && (wa1 == AW'(gi)) && addr_live(wa1);
            assign wr_any[gi]  = wr_hit0[gi] | wr_hit1[gi];
            assign clm_hit[gi] = claim_en && (claim_a == AW'(gi)) && addr_live(claim_a);

            // Port 1 wins a same-address collision.
            assign regs_d[gi] = wr_hit1[gi] ? wd1 :
                                wr_hit0[gi] ? wd0 : regs_q[gi];

            // A claim always leaves the bit set. Otherwise, any write retires it.
            assign pend_d[gi] = clm_hit[gi] | (pend_q[gi] & ~wr_any[gi]);
        end
    endgenerate

    // A claim is rejected only if the register is already pending and is
    // not retired by a write in this cycle.
    assign claim_err_d = |(clm_hit & pend_q & ~wr_any);

    // Register file, scoreboard and error flag. Reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q      <= '0;
            claim_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q      <= pend_d;
            claim_err_q <= claim_err_d;
        end
    end

    assign claim_err = claim_err_q;

    // The three read ports share one implementation.
    logic [AW-1:0] ra_v   [3];
    logic [DW-1:0] rd_v   [3];
    logic          busy_v [3];

    assign ra_v[0] = ra1;
    assign ra_v[1] = ra2;
    assign ra_v[2] = ra3;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            // Read mux. It forwards this cycle's write data when bypassing is enabled.
            // Outputs are forced to 0 while reset is held.
            always_comb begin
                rd_v[gi]   = '0;
                busy_v[gi] = 1'b0;
                if (rst && addr_live(ra_v[gi])) begin
                    rd_v[gi]   = regs_q[ra_v[gi]];
                    busy_v[gi] = pend_q[ra_v[gi]];
                    if (BYPASS != 0) begin
                        if (wr_hit1[ra_v[gi]]) begin
                            rd_v[gi] = wd1;
                        end else if (wr_hit0[ra_v[gi]]) begin
                            rd_v[gi] = wd0;
                        end
                        if (wr_any[ra_v[gi]] && !clm_hit[ra_v[gi]]) begin
                            busy_v[gi] = 1'b0;
                        end
                    end
                end
            end
        end
    endgenerate

    assign rd1   = rd_v[0];
    assign rd2   = rd_v[1];
    assign rd3   = rd_v[2];
    assign busy1 = busy_v[0];
    assign busy2 = busy_v[1];
    assign busy3 = busy_v[2];

endmodule

// File: tb/tb_reg_bank_mp.sv
// Testbench for reg_bank_mp. Three instances receive the same stimulus:
//   index 0: BYPASS=1, ZERO_R0=0
//   index 1: BYPASS=0, ZERO_R0=0
//   index 2: BYPASS=1, ZERO_R0=1
// A behavioural model of the register file is checked on every falling edge.
// Directed steps with literal expectations are followed by random traffic.
module tb_reg_bank_mp;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 3;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ra1, ra2, ra3;
    logic          we0, we1, claim_en;
    logic [AW-1:0] wa0, wa1, claim_a;
    logic [DW-1:0] wd0, wd1;

    logic [DW-1:0] rd1_w [N];
    logic [DW-1:0] rd2_w [N];
    logic [DW-1:0] rd3_w [N];
    logic          busy1_w [N];
    logic          busy2_w [N];
    logic          busy3_w [N];
    logic          cerr_w [N];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  cmp_on = 1'b0;

    always #5 clk = ~clk;

    reg_bank_mp #(.DW(DW), .AW(AW), .BYPASS(1), .ZERO_R0(0)) u_a (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rd1(rd1_w[0]), .rd2(rd2_w[0]), .rd3(rd3_w[0]),
        .busy1(busy1_w[0]), .busy2(busy2_w[0]), .busy3(busy3_w[0]),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .claim_en(claim_en), .claim_a(claim_a), .claim_err(cerr_w[0]));

    reg_bank_mp #(.DW(DW), .AW(AW), .BYPASS(0), .ZERO_R0(0)) u_b (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rd1(rd1_w[1]), .rd2(rd2_w[1]), .rd3(rd3_w[1]),
        .busy1(busy1_w[1]), .busy2(busy2_w[1]), .busy3(busy3_w[1]),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .claim_en(claim_en), .claim_a(claim_a), .claim_err(cerr_w[1]));

    reg_bank_mp #(.DW(DW), .AW(AW), .BYPASS(1), .ZERO_R0(1)) u_c (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rd1(rd1_w[2]), .rd2(rd2_w[2]), .rd3(rd3_w[2]),
        .busy1(busy1_w[2]), .busy2(busy2_w[2]), .busy3(busy3_w[2]),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .claim_en(claim_en), .claim_a(claim_a), .claim_err(cerr_w[2]));

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem  [N][D];
    bit            m_pend [N][D];
    bit            m_err  [N];

    function automatic bit cfg_byp(input int i);
        return (i != 1);
    endfunction

    function automatic bit live(input int i, input logic [AW-1:0] a);
        return !((i == 2) && (a == '0));
    endfunction

    // Model state. Writes happen in port order so that port 1 lands last.
    // A claim is applied after the writes so that it leaves the bit set.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_err[i] <= 1'b0;
                for (int a = 0; a < D; a++) begin
                    m_mem[i][a]  <= '0;
                    m_pend[i][a] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_err[i] <= claim_en && live(i, claim_a) && m_pend[i][claim_a] &&
                            !((we0 && wa0 == claim_a) || (we1 && wa1 == claim_a));
                if (we0 && live(i, wa0)) begin
                    m_mem[i][wa0]  <= wd0;
                    m_pend[i][wa0] <= 1'b0;
                end
                if (we1 && live(i, wa1)) begin
                    m_mem[i][wa1]  <= wd1;
                    m_pend[i][wa1] <= 1'b0;
                end
                if (claim_en && live(i, claim_a)) begin
                    m_pend[i][claim_a] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input int i, input logic [AW-1:0] a);
        if (!rst || !live(i, a)) return '0;
        if (cfg_byp(i)) begin
            if (we1 && wa1 == a) return wd1;
            if (we0 && wa0 == a) return wd0;
        end
        return m_mem[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input logic [AW-1:0] a);
        if (!rst || !live(i, a)) return 1'b0;
        if (cfg_byp(i) && ((we0 && wa0 == a) || (we1 && wa1 == a)) &&
            !(claim_en && claim_a == a)) return 1'b0;
        return m_pend[i][a];
    endfunction

    task automatic chk(input string nm, input int i, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Compare every output of every instance against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < N; i++) begin
                chk("rd1", i, rd1_w[i], exp_rd(i, ra1));
                chk("rd2", i, rd2_w[i], exp_rd(i, ra2));
                chk("rd3", i, rd3_w[i], exp_rd(i, ra3));
                chk("busy1", i, DW'(busy1_w[i]), DW'(exp_busy(i, ra1)));
                chk("busy2", i, DW'(busy2_w[i]), DW'(exp_busy(i, ra2)));
                chk("busy3", i, DW'(busy3_w[i]), DW'(exp_busy(i, ra3)));
                chk("claim_err", i, DW'(cerr_w[i]), DW'(m_err[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        claim_en = 1'b0; claim_a = '0;
        ra1 = '0; ra2 = '0; ra3 = '0;
    endtask

    // Advance to just after the next rising edge and clear all inputs.
    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        cmp_on = 1'b1;
        // A write during reset is ignored, and the outputs stay 0.
        we0 = 1'b1; wa0 = 3'd1; wd0 = 16'hBEEF; ra1 = 3'd1;
        #2;
        chk("rst_rd1", 0, rd1_w[0], 16'h0000);
        chk("rst_busy1", 0, DW'(busy1_w[0]), 16'h0);
        idle();
        #10 rst = 1'b1;

        // Write r2, then read it back.
        nxt(); we0 = 1'b1; wa0 = 3'd2; wd0 = 16'h1234; ra1 = 3'd2;
        @(negedge clk);
        chk("byp_rd1", 0, rd1_w[0], 16'h1234);
        chk("nobyp_rd1", 1, rd1_w[1], 16'h0000);
        nxt(); ra1 = 3'd2; ra2 = 3'd3;
        @(negedge clk);
        chk("r2_rd1", 1, rd1_w[1], 16'h1234);
        chk("r3_rd2", 0, rd2_w[0], 16'h0000);

        // Same-address collision: port 1 wins.
        nxt(); we0 = 1'b1; wa0 = 3'd5; wd0 = 16'hAAAA;
        we1 = 1'b1; wa1 = 3'd5; wd1 = 16'h5555; ra1 = 3'd5;
        @(negedge clk);
        chk("coll_byp", 0, rd1_w[0], 16'h5555);
        nxt(); ra1 = 3'd5;
        @(negedge clk);
        chk("coll_store", 1, rd1_w[1], 16'h5555);

        // Without bypass, new data appears one cycle late.
        nxt(); we0 = 1'b1; wa0 = 3'd3; wd0 = 16'h00FF; ra2 = 3'd3;
        @(negedge clk);
        chk("nobyp_old", 1, rd2_w[1], 16'h0000);
        nxt(); ra2 = 3'd3;
        @(negedge clk);
        chk("nobyp_new", 1, rd2_w[1], 16'h00FF);

        // Claim r4, claim it again (rejected), then retire it with a write.
        nxt(); claim_en = 1'b1; claim_a = 3'd4; ra1 = 3'd4;
        @(negedge clk);
        chk("clm_busy0", 0, DW'(busy1_w[0]), 16'h0);
        nxt(); claim_en = 1'b1; claim_a = 3'd4; ra1 = 3'd4;
        @(negedge clk);
        chk("clm_busy1", 0, DW'(busy1_w[0]), 16'h1);
        chk("clm_err0", 0, DW'(cerr_w[0]), 16'h0);
        nxt(); we0 = 1'b1; wa0 = 3'd4; wd0 = 16'h0007; ra1 = 3'd4;
        @(negedge clk);
        chk("clm_err1", 0, DW'(cerr_w[0]), 16'h1);
        chk("wr_busy_byp", 0, DW'(busy1_w[0]), 16'h0);
        chk("wr_busy_nobyp", 1, DW'(busy1_w[1]), 16'h1);
        nxt(); ra1 = 3'd4;
        @(negedge clk);
        chk("clm_err_clr", 0, DW'(cerr_w[0]), 16'h0);
        chk("busy_clr", 1, DW'(busy1_w[1]), 16'h0);
        chk("r4_val", 1, rd1_w[1], 16'h0007);

        // Claim and write in the same cycle: the claim wins, and the data is stored.
        nxt(); claim_en = 1'b1; claim_a = 3'd6; we1 = 1'b1; wa1 = 3'd6;
        wd1 = 16'h0042; ra1 = 3'd6;
        @(negedge clk);
        chk("cw_busy_now", 0, DW'(busy1_w[0]), 16'h0);
        nxt(); ra1 = 3'd6;
        @(negedge clk);
        chk("cw_rd", 0, rd1_w[0], 16'h0042);
        chk("cw_busy", 0, DW'(busy1_w[0]), 16'h1);
        chk("cw_err", 0, DW'(cerr_w[0]), 16'h0);

        // Claim a pending register while it is being written: accepted.
        nxt(); claim_en = 1'b1; claim_a = 3'd6; we0 = 1'b1; wa0 = 3'd6;
        wd0 = 16'h0099; ra1 = 3'd6;
        @(negedge clk);
        chk("pcw_busy_now", 0, DW'(busy1_w[0]), 16'h1);
        nxt(); ra1 = 3'd6;
        @(negedge clk);
        chk("pcw_err", 0, DW'(cerr_w[0]), 16'h0);
        chk("pcw_busy", 0, DW'(busy1_w[0]), 16'h1);
        chk("pcw_rd", 0, rd1_w[0], 16'h0099);

        // Write and claim r0: r0 stays zero in the ZERO_R0 build.
        nxt(); we0 = 1'b1; wa0 = 3'd0; wd0 = 16'hFFFF; claim_en = 1'b1;
        claim_a = 3'd0; ra1 = 3'd0;
        @(negedge clk);
        chk("z_rd_now", 2, rd1_w[2], 16'h0000);
        chk("z_byp_other", 0, rd1_w[0], 16'hFFFF);
        nxt(); ra1 = 3'd0; claim_en = 1'b1; claim_a = 3'd0;
        @(negedge clk);
        chk("z_rd", 2, rd1_w[2], 16'h0000);
        chk("z_busy", 2, DW'(busy1_w[2]), 16'h0);
        chk("nz_busy", 0, DW'(busy1_w[0]), 16'h1);
        nxt(); ra1 = 3'd0;
        @(negedge clk);
        chk("z_err", 2, DW'(cerr_w[2]), 16'h0);
        chk("nz_err", 0, DW'(cerr_w[0]), 16'h1);

        // Assert reset mid-cycle while a write is pending.
        nxt(); we0 = 1'b1; wa0 = 3'd2; wd0 = 16'hABCD; ra1 = 3'd2; ra2 = 3'd6; ra3 = 3'd5;
        #2 rst = 1'b0;
        #1;
        chk("mrst_rd1", 0, rd1_w[0], 16'h0000);
        chk("mrst_rd2", 1, rd2_w[1], 16'h0000);
        chk("mrst_rd3", 1, rd3_w[1], 16'h0000);
        chk("mrst_busy2", 0, DW'(busy2_w[0]), 16'h0);
        chk("mrst_err", 0, DW'(cerr_w[0]), 16'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("mrst_lost", 1, rd1_w[1], 16'h0000);
        chk("mrst_r5", 1, rd3_w[1], 16'h0000);
        nxt(); ra1 = 3'd2;
        @(negedge clk);
        chk("mrst_first", 1, rd1_w[1], 16'hABCD);

        // Random traffic, with an occasional mid-cycle reset.
        for (int k = 0; k < 3000; k++) begin
            nxt();
            we0 = ($urandom_range(0, 99) < 50);
            wa0 = AW'($urandom_range(0, D - 1));
            wd0 = DW'($urandom);
            we1 = ($urandom_range(0, 99) < 40);
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, D - 1));
            wd1 = DW'($urandom);
            claim_en = ($urandom_range(0, 99) < 35);
            claim_a = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, D - 1));
            ra1 = ($urandom_range(0, 1) == 0) ? wa0 : AW'($urandom_range(0, D - 1));
            ra2 = ($urandom_range(0, 1) == 0) ? wa1 : AW'($urandom_range(0, D - 1));
            ra3 = ($urandom_range(0, 1) == 0) ? claim_a : AW'($urandom_range(0, D - 1));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                @(posedge clk);
                #3 rst = 1'b1;
            end
        end

        nxt();
        @(negedge clk);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
